store_drain_buffer: RTL and testbench

- Receives retired stores from the commit stage, at most one per cycle, and queues them in order.
- Drains the queue to the data-memory write port over a valid/ready handshake, generating word-aligned addresses, byte strobes and lane-replicated write data from ldst_mode_t.
- Asserts sb_full so commit holds store retirement; asserts sb_empty for fence/halt logic.

---
 rtl/store_drain_buffer_pkg.sv | 28 ++
 rtl/store_drain_buffer_if.sv | 18 +
 rtl/store_drain_buffer_store_format.sv | 40 ++++
 rtl/store_drain_buffer.sv | 119 +++++++++++
 tb/tb_store_drain_buffer.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/store_drain_buffer_pkg.sv
// Shared types and constants for the store drain buffer and the load/store
// formatting logic.
package store_drain_buffer_pkg;

  typedef logic bool;

  typedef enum logic [2:0] {
    BYTE   = 3'd0,
    HALF   = 3'd1,
    WORD   = 3'd2,
    BYTE_U = 3'd3,
    HALF_U = 3'd4
  } ldst_mode_t;

  localparam int BUF_SIZE     = 8;
  localparam int BUF_SIZE_LOG = 3;

  localparam int SB_DEPTH     = 4;
  localparam int SB_DEPTH_LOG = 2;

  // One queued store, already formatted for the data-memory write port.
  typedef struct packed {
    logic [29:0] word_addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
  } sb_entry_t;

endpackage

// File: rtl/store_drain_buffer_if.sv
// Data-memory write port between the store drain buffer (master) and memory
// (slave).
// Handshake: a write transfers on every rising clk edge where mem_req and
// mem_ready are both high; while mem_req is high and mem_ready low the master
// holds mem_addr/mem_wdata/mem_strb stable; mem_ready with mem_req low is
// ignored.
interface store_drain_buffer_if;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_strb;
  logic        mem_ready;

  modport master (output mem_req, output mem_addr, output mem_wdata,
                  output mem_strb, input mem_ready);
  modport slave  (input mem_req, input mem_addr, input mem_wdata,
                  input mem_strb, output mem_ready);
endinterface

// File: rtl/store_drain_buffer_store_format.sv
// Combinational store formatter: byte strobes, lane-replicated write data and
// an alignment error from access size and the low address bits. Unsigned
// modes behave as their signed counterparts; unknown encodings are rejected
// as misaligned so they never reach memory.
import store_drain_buffer_pkg::*;

module store_format (
  input  ldst_mode_t  i_mode,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_data,
  output logic [3:0]  o_strb,
  output logic [31:0] o_wdata,
  output logic        o_misaligned
);

  // Decode size into strobes/replicated data and flag misalignment.
  always_comb begin
    o_strb       = 4'b0000;
    o_wdata      = 32'h0;
    o_misaligned = 1'b0;
    case (i_mode)
      BYTE, BYTE_U: begin
        o_strb  = 4'b0001 << i_addr_lo;
        o_wdata = {4{i_data[7:0]}};
      end
      HALF, HALF_U: begin
        o_misaligned = i_addr_lo[0];
        o_strb       = i_addr_lo[1] ? 4'b1100 : 4'b0011;
        o_wdata      = {2{i_data[15:0]}};
      end
      WORD: begin
        o_misaligned = (i_addr_lo != 2'b00);
        o_strb       = 4'b1111;
        o_wdata      = i_data;
      end
      default: o_misaligned = 1'b1;
    endcase
  end

endmodule

// File: rtl/store_drain_buffer.sv
// In-order store drain buffer between commit and the data-memory write port.
// Optional load-conflict check enabled by defining STORE_BUFFER_FWD_CHECK_EN.
import store_drain_buffer_pkg::*;

module store_drain_buffer #(
  parameter int SB_DEPTH     = store_drain_buffer_pkg::SB_DEPTH,
  parameter int SB_DEPTH_LOG = store_drain_buffer_pkg::SB_DEPTH_LOG
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  store_enable,
  input  ldst_mode_t            store_mode,
  input  logic [31:0]           store_addr,
  input  logic [31:0]           store_data,
  output logic                  sb_full,
  output logic                  sb_empty,
  output logic                  sb_error,
`ifdef STORE_BUFFER_FWD_CHECK_EN
  input  logic                  ld_check,
  input  logic [31:0]           ld_addr,
  output logic                  ld_conflict,
`endif
  store_drain_buffer_if.master  mem
);

  localparam logic [SB_DEPTH_LOG:0] FULL_CNT = (SB_DEPTH_LOG+1)'(SB_DEPTH);

  sb_entry_t               r_mem [SB_DEPTH];
  logic [SB_DEPTH_LOG-1:0] r_head;
  logic [SB_DEPTH_LOG-1:0] r_tail;
  logic [SB_DEPTH_LOG:0]   r_count;
  logic                    r_error;

  logic [3:0]  w_strb;
  logic [31:0] w_wdata;
  logic        w_misaligned;
  logic        w_full;
  logic        w_empty;
  logic        w_enq;
  logic        w_deq;
  sb_entry_t   w_new_entry;
  sb_entry_t   w_head_entry;

  store_format u_fmt (
    .i_mode       (store_mode),
    .i_addr_lo    (store_addr[1:0]),
    .i_data       (store_data),
    .o_strb       (w_strb),
    .o_wdata      (w_wdata),
    .o_misaligned (w_misaligned)
  );

  assign w_full       = (r_count == FULL_CNT);
  assign w_empty      = (r_count == '0);
  assign w_enq        = store_enable && !w_full && !w_misaligned;
  assign w_deq        = !w_empty && mem.mem_ready;
  assign w_new_entry  = '{word_addr: store_addr[31:2], wdata: w_wdata, strb: w_strb};
  assign w_head_entry = r_mem[r_head];

  // Outputs come straight from the head entry; gating with empty keeps them
  // zero out of reset without needing to reset the storage array.
  assign sb_full       = w_full;
  assign sb_empty      = w_empty;
  assign sb_error      = r_error;
  assign mem.mem_req   = !w_empty;
  assign mem.mem_addr  = w_empty ? 32'h0 : {w_head_entry.word_addr, 2'b00};
  assign mem.mem_wdata = w_empty ? 32'h0 : w_head_entry.wdata;
  assign mem.mem_strb  = w_empty ? 4'h0  : w_head_entry.strb;

  // Entry storage: write the formatted store at the tail slot.
  always_ff @(posedge clk) begin
    if (w_enq) r_mem[r_tail] <= w_new_entry;
  end

  // Pointers and occupancy; simultaneous enqueue and dequeue keeps count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_enq) r_tail <= r_tail + 1'b1;
      if (w_deq) r_head <= r_head + 1'b1;
      case ({w_enq, w_deq})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Sticky error on any rejected store (misaligned or buffer full).
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                        r_error <= 1'b0;
    else if (store_enable && (w_full || w_misaligned)) r_error <= 1'b1;
  end

`ifdef STORE_BUFFER_FWD_CHECK_EN
  logic                    w_hit;
  logic [SB_DEPTH_LOG-1:0] w_off;
  logic                    w_unused_ld_lo;

  assign w_unused_ld_lo = &{1'b0, ld_addr[1:0]};

  // Word-address match against occupied slots only (distance from head < count).
  always_comb begin
    w_hit = 1'b0;
    w_off = '0;
    for (int i = 0; i < SB_DEPTH; i++) begin
      w_off = SB_DEPTH_LOG'(i) - r_head;
      if (({1'b0, w_off} < r_count) && (r_mem[i].word_addr == ld_addr[31:2]))
        w_hit = 1'b1;
    end
  end

  assign ld_conflict = ld_check && w_hit;
`endif

endmodule

// File: tb/tb_store_drain_buffer.sv
// Directed bench for store_drain_buffer: reset values, formatting, full and
// overflow handling, in-order drain with wrap, alignment errors, concurrent
// enqueue/dequeue and asynchronous reset. Optional STORE_BUFFER_FWD_CHECK_EN.
import store_drain_buffer_pkg::*;

module tb_store_drain_buffer;

  logic        clk;
  logic        reset;
  logic        store_enable;
  ldst_mode_t  store_mode;
  logic [31:0] store_addr;
  logic [31:0] store_data;
  logic        sb_full;
  logic        sb_empty;
  logic        sb_error;
`ifdef STORE_BUFFER_FWD_CHECK_EN
  logic        ld_check;
  logic [31:0] ld_addr;
  logic        ld_conflict;
`endif

  store_drain_buffer_if mem_if ();

  store_drain_buffer dut (
    .clk          (clk),
    .reset        (reset),
    .store_enable (store_enable),
    .store_mode   (store_mode),
    .store_addr   (store_addr),
    .store_data   (store_data),
    .sb_full      (sb_full),
    .sb_empty     (sb_empty),
    .sb_error     (sb_error),
`ifdef STORE_BUFFER_FWD_CHECK_EN
    .ld_check     (ld_check),
    .ld_addr      (ld_addr),
    .ld_conflict  (ld_conflict),
`endif
    .mem          (mem_if.master)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Scoreboard: {addr, wdata} of every write memory must see, in order
  logic [63:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_store(input ldst_mode_t m, input logic [31:0] a, input logic [31:0] d);
    store_enable = 1'b1;
    store_mode   = m;
    store_addr   = a;
    store_data   = d;
  endtask

  task automatic drive_idle();
    store_enable = 1'b0;
    store_mode   = BYTE;
    store_addr   = 32'h0;
    store_data   = 32'h0;
  endtask

  initial begin
    reset = 1'b1;
    mem_if.mem_ready = 1'b0;
    drive_idle();
`ifdef STORE_BUFFER_FWD_CHECK_EN
    ld_check = 1'b0;
    ld_addr  = 32'h0;
`endif
    #12;
    check("rst_empty", 32'(sb_empty), 32'd1);
    check("rst_full",  32'(sb_full),  32'd0);
    check("rst_req",   32'(mem_if.mem_req), 32'd0);
    check("rst_addr",  mem_if.mem_addr,  32'h0);
    check("rst_wdata", mem_if.mem_wdata, 32'h0);
    check("rst_strb",  32'(mem_if.mem_strb), 32'h0);
    check("rst_error", 32'(sb_error), 32'd0);
    reset = 1'b0;

    // BYTE store, one-cycle latency, then drain
    step();
    drive_store(BYTE, 32'h1003, 32'h0000_00AB);
    step();
    drive_idle();
    check("byte_req",   32'(mem_if.mem_req), 32'd1);
    check("byte_addr",  mem_if.mem_addr, 32'h1000);
    check("byte_strb",  32'(mem_if.mem_strb), 32'h8);
    check("byte_wdata", mem_if.mem_wdata, 32'hABAB_ABAB);
    mem_if.mem_ready = 1'b1;
    step();
    mem_if.mem_ready = 1'b0;
    check("byte_drained_empty", 32'(sb_empty), 32'd1);
    check("byte_drained_req",   32'(mem_if.mem_req), 32'd0);

    // Fill with 4 WORD stores while memory stalls
    for (int i = 0; i < 4; i++) begin
      drive_store(WORD, 32'h100 + 32'(4 * i), 32'hA000_0000 + 32'(i));
      exp_q.push_back({32'h100 + 32'(4 * i), 32'hA000_0000 + 32'(i)});
      step();
      check("fill_addr_stable",  mem_if.mem_addr,  32'h100);
      check("fill_wdata_stable", mem_if.mem_wdata, 32'hA000_0000);
      check("fill_full", 32'(sb_full), (i == 3) ? 32'd1 : 32'd0);
    end
    // Overflow attempt
    drive_store(WORD, 32'h200, 32'hDEAD_BEEF);
    step();
    drive_idle();
    check("ovf_error", 32'(sb_error), 32'd1);
    check("ovf_full",  32'(sb_full),  32'd1);
    check("ovf_addr_stable", mem_if.mem_addr, 32'h100);

    // Drain 6 writes while committing 2 more (pointer wrap)
    for (int c = 0; c < 6; c++) begin
      mem_if.mem_ready = 1'b1;
      if (c == 1 || c == 2) begin
        drive_store(WORD, 32'h110 + 32'(4 * (c - 1)), 32'h5555_0000 + 32'(c));
        exp_q.push_back({32'h110 + 32'(4 * (c - 1)), 32'h5555_0000 + 32'(c)});
      end else begin
        drive_idle();
      end
      check("drain_req", 32'(mem_if.mem_req), 32'd1);
      if (exp_q.size() != 0) begin
        check("drain_addr",  mem_if.mem_addr,  exp_q[0][63:32]);
        check("drain_wdata", mem_if.mem_wdata, exp_q[0][31:0]);
        check("drain_strb",  32'(mem_if.mem_strb), 32'hF);
        exp_q.pop_front();
      end
      step();
    end
    drive_idle();
    mem_if.mem_ready = 1'b0;
    check("drain_done_empty", 32'(sb_empty), 32'd1);
    check("drain_sb_size", 32'(exp_q.size()), 32'd0);

    // Clear sticky error, then HALF alignment cases
    reset = 1'b1;
    #3;
    check("rst_clears_error", 32'(sb_error), 32'd0);
    reset = 1'b0;
    drive_store(HALF, 32'h2001, 32'h0000_1234);
    step();
    drive_idle();
    check("half_mis_error", 32'(sb_error), 32'd1);
    check("half_mis_empty", 32'(sb_empty), 32'd1);
    drive_store(HALF_U, 32'h2002, 32'h0000_1234);
    step();
    drive_idle();
    check("half_addr",  mem_if.mem_addr, 32'h2000);
    check("half_strb",  32'(mem_if.mem_strb), 32'hC);
    check("half_wdata", mem_if.mem_wdata, 32'h1234_1234);
    mem_if.mem_ready = 1'b1;
    step();
    mem_if.mem_ready = 1'b0;
    check("half_drained", 32'(sb_empty), 32'd1);

    // count==1 with simultaneous enqueue and dequeue
    drive_store(BYTE_U, 32'h3000, 32'h0000_005A);
    step();
    check("c1_addr",  mem_if.mem_addr, 32'h3000);
    check("c1_strb",  32'(mem_if.mem_strb), 32'h1);
    check("c1_wdata", mem_if.mem_wdata, 32'h5A5A_5A5A);
    drive_store(WORD, 32'h3004, 32'hCAFE_F00D);
    mem_if.mem_ready = 1'b1;
    step();
    drive_idle();
    check("c1_req_held", 32'(mem_if.mem_req), 32'd1);
    check("c1_next_addr",  mem_if.mem_addr, 32'h3004);
    check("c1_next_wdata", mem_if.mem_wdata, 32'hCAFE_F00D);
    check("c1_next_strb",  32'(mem_if.mem_strb), 32'hF);
    step();
    mem_if.mem_ready = 1'b0;
    check("c1_count_was_1", 32'(sb_empty), 32'd1);

    // Three pending entries, then asynchronous reset
    for (int i = 0; i < 3; i++) begin
      drive_store(WORD, 32'h4000 + 32'(4 * i), 32'h7700_0000 + 32'(i));
      step();
    end
    drive_idle();
`ifdef STORE_BUFFER_FWD_CHECK_EN
    ld_check = 1'b1;
    ld_addr  = 32'h4006;
    #1;
    check("fwd_hit", 32'(ld_conflict), 32'd1);
    ld_addr  = 32'h400C;
    #1;
    check("fwd_miss", 32'(ld_conflict), 32'd0);
    mem_if.mem_ready = 1'b1;
    step();
    mem_if.mem_ready = 1'b0;
    ld_addr = 32'h4000;
    #1;
    check("fwd_drained_miss", 32'(ld_conflict), 32'd0);
    ld_addr = 32'h4004;
    #1;
    check("fwd_pending_hit", 32'(ld_conflict), 32'd1);
`endif
    check("pend_req", 32'(mem_if.mem_req), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_req",   32'(mem_if.mem_req), 32'd0);
    check("async_rst_empty", 32'(sb_empty), 32'd1);
`ifdef STORE_BUFFER_FWD_CHECK_EN
    check("async_rst_fwd", 32'(ld_conflict), 32'd0);
`endif
    #2;
    reset = 1'b0;
    step();
    check("post_rst_empty", 32'(sb_empty), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
